ex_stage: RTL and testbench

- Execute stage of the 5-stage in-order pipeline, between ID and MEM.
- Registers the ID→EX bus and computes the ALU result or load/store address.
- Drives the data SRAM request and produces the ex_to_mem_bus that MEM consumes.
- Owns HI/LO and an iterative 32-cycle divider; stalls the pipeline while a divide runs.

---
 rtl/ex_stage_pkg.sv | 44 ++++
 rtl/ex_stage_div_iter.sv | 86 ++++++++
 rtl/ex_stage.sv | 184 ++++++++++++++++++
 tb/tb_ex_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared constants, opcode encodings and helpers for the execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 140;
    localparam int EX_TO_MEM_WD = 76;
    localparam int STALL_BUS    = 6;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    // Restoring steps per divide; the divider counter compares against this.
    localparam logic [5:0] DIV_CYCLES = 6'd32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10,
        ALU_DIV  = 4'd11,
        ALU_DIVU = 4'd12,
        ALU_MFHI = 4'd13,
        ALU_MFLO = 4'd14,
        ALU_PASS = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_LW   = 2'b01,
        MEM_SW   = 2'b10,
        MEM_SB   = 2'b11
    } mem_op_e;

    function automatic logic [3:0] sb_wen(input logic [1:0] offset);
        return 4'b0001 << offset;
    endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Iterative restoring divider: one load cycle, 32 step cycles, one result cycle.
module div_iter
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] quot,
    output logic [31:0] rem
);

    logic        busy_r;
    logic [5:0]  cnt_r;
    logic [31:0] dvd_r;
    logic [31:0] dvs_r;
    logic [31:0] rem_r;
    logic        q_neg_r;
    logic        r_neg_r;
    logic        b_zero_r;

    logic        a_neg_s;
    logic        b_neg_s;
    logic [32:0] partial_s;
    logic        ge_s;
    logic [31:0] rem_next_s;

    assign a_neg_s = signed_op & a[31];
    assign b_neg_s = signed_op & b[31];

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        partial_s  = {rem_r, dvd_r[31]};
        ge_s       = (partial_s >= {1'b0, dvs_r});
        rem_next_s = 32'd0;
        if (ge_s) begin
            rem_next_s = partial_s[31:0] - dvs_r;
        end else begin
            rem_next_s = partial_s[31:0];
        end
    end

    // Divider state: load magnitudes on start, iterate while busy, retire after the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r   <= 1'b0;
            cnt_r    <= 6'd0;
            dvd_r    <= 32'd0;
            dvs_r    <= 32'd0;
            rem_r    <= 32'd0;
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            b_zero_r <= 1'b0;
        end else if (start && !busy_r) begin
            busy_r   <= 1'b1;
            cnt_r    <= 6'd0;
            dvd_r    <= a_neg_s ? (32'd0 - a) : a;
            dvs_r    <= b_neg_s ? (32'd0 - b) : b;
            rem_r    <= 32'd0;
            q_neg_r  <= a_neg_s ^ b_neg_s;
            r_neg_r  <= a_neg_s;
            b_zero_r <= (b == 32'd0);
        end else if (busy_r) begin
            if (cnt_r == DIV_CYCLES) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + 6'd1;
                dvd_r <= {dvd_r[30:0], ge_s};
                rem_r <= rem_next_s;
            end
        end else begin
            busy_r <= busy_r;
        end
    end

    assign busy = busy_r;
    assign done = busy_r && (cnt_r == DIV_CYCLES);
    // Divide by zero reports all-ones quotient; the remainder path already yields the dividend.
    assign quot = b_zero_r ? 32'hFFFF_FFFF : (q_neg_r ? (32'd0 - dvd_r) : dvd_r);
    assign rem  = r_neg_r ? (32'd0 - rem_r) : rem_r;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID->EX register, ALU, load/store request generation and HI/LO with divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_BUS-1:0]    stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [37:0]             ex_to_id,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    logic [ID_TO_EX_WD-1:0] ireg_r;
    logic [31:0]            hi_r;
    logic [31:0]            lo_r;
    logic                   div_done_r;

    logic        bubble_s;
    logic        capture_s;
    logic [31:0] pc_s;
    alu_op_e     alu_op_s;
    logic [31:0] src1_s;
    logic [31:0] src2_s;
    mem_op_e     mem_op_s;
    logic        rf_we_s;
    logic [4:0]  rf_waddr_s;
    logic [31:0] store_data_s;
    logic [31:0] alu_res_s;
    logic [31:0] addr_s;
    logic [31:0] ex_result_s;
    logic        mem_en_s;
    logic [3:0]  mem_wen_s;
    logic [31:0] mem_wdata_s;
    logic        is_div_s;
    logic        div_start_s;
    logic        div_busy_s;
    logic        div_done_s;
    logic [31:0] div_quot_s;
    logic [31:0] div_rem_s;
    logic        unused_stall_s;

    assign bubble_s       = (stall[2] == STOP) && (stall[3] == NO_STOP);
    assign capture_s      = (stall[2] == NO_STOP);
    assign unused_stall_s = ^{stall[5:4], stall[1:0]};

    // ID->EX input register: bubble beats capture, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            ireg_r <= {ID_TO_EX_WD{1'b0}};
        end else if (bubble_s) begin
            ireg_r <= {ID_TO_EX_WD{1'b0}};
        end else if (capture_s) begin
            ireg_r <= id_to_ex_bus;
        end else begin
            ireg_r <= ireg_r;
        end
    end

    assign pc_s         = ireg_r[139:108];
    assign alu_op_s     = alu_op_e'(ireg_r[107:104]);
    assign src1_s       = ireg_r[103:72];
    assign src2_s       = ireg_r[71:40];
    assign mem_op_s     = mem_op_e'(ireg_r[39:38]);
    assign rf_we_s      = ireg_r[37];
    assign rf_waddr_s   = ireg_r[36:32];
    assign store_data_s = ireg_r[31:0];

    // ALU result selection.
    always_comb begin
        alu_res_s = 32'd0;
        case (alu_op_s)
            ALU_ADD:  alu_res_s = src1_s + src2_s;
            ALU_SUB:  alu_res_s = src1_s - src2_s;
            ALU_AND:  alu_res_s = src1_s & src2_s;
            ALU_OR:   alu_res_s = src1_s | src2_s;
            ALU_XOR:  alu_res_s = src1_s ^ src2_s;
            ALU_SLL:  alu_res_s = src2_s << src1_s[4:0];
            ALU_SRL:  alu_res_s = src2_s >> src1_s[4:0];
            ALU_SRA:  alu_res_s = $unsigned($signed(src2_s) >>> src1_s[4:0]);
            ALU_SLT:  alu_res_s = {31'd0, ($signed(src1_s) < $signed(src2_s))};
            ALU_SLTU: alu_res_s = {31'd0, (src1_s < src2_s)};
            ALU_LUI:  alu_res_s = {src2_s[15:0], 16'd0};
            ALU_DIV:  alu_res_s = 32'd0;
            ALU_DIVU: alu_res_s = 32'd0;
            ALU_MFHI: alu_res_s = hi_r;
            ALU_MFLO: alu_res_s = lo_r;
            ALU_PASS: alu_res_s = src1_s;
            default:  alu_res_s = 32'd0;
        endcase
    end

    assign addr_s = src1_s + src2_s;

    // Data SRAM request; repeats harmlessly while EX is held.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_wen_s   = 4'b0000;
        mem_wdata_s = 32'd0;
        case (mem_op_s)
            MEM_NONE: begin
                mem_en_s = 1'b0;
            end
            MEM_LW: begin
                mem_en_s = 1'b1;
            end
            MEM_SW: begin
                mem_en_s    = 1'b1;
                mem_wen_s   = 4'b1111;
                mem_wdata_s = store_data_s;
            end
            MEM_SB: begin
                mem_en_s    = 1'b1;
                mem_wen_s   = sb_wen(addr_s[1:0]);
                mem_wdata_s = {4{store_data_s[7:0]}};
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    assign ex_result_s = (mem_op_s != MEM_NONE) ? addr_s : alu_res_s;

    assign is_div_s    = (alu_op_s == ALU_DIV) || (alu_op_s == ALU_DIVU);
    assign div_start_s = is_div_s && !div_busy_s && !div_done_r;

    div_iter u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .signed_op (alu_op_s == ALU_DIV),
        .a         (src1_s),
        .b         (src2_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .quot      (div_quot_s),
        .rem       (div_rem_s)
    );

    // A finished divide stays retired until a new instruction or bubble enters EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_done_r <= 1'b0;
        end else if (bubble_s || capture_s) begin
            div_done_r <= 1'b0;
        end else if (div_done_s) begin
            div_done_r <= 1'b1;
        end else begin
            div_done_r <= div_done_r;
        end
    end

    // HI/LO written once, on the divider result cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (div_done_s) begin
            hi_r <= div_rem_s;
            lo_r <= div_quot_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign stallreq_for_ex = div_start_s || (div_busy_s && !div_done_s);

    assign data_sram_en    = mem_en_s;
    assign data_sram_wen   = mem_wen_s;
    assign data_sram_addr  = addr_s;
    assign data_sram_wdata = mem_wdata_s;

    assign ex_is_load    = (mem_op_s == MEM_LW);
    assign ex_to_id      = {rf_we_s, rf_waddr_s, ex_result_s};
    assign ex_to_mem_bus = {pc_s, mem_en_s, mem_wen_s, 1'b0, rf_we_s, rf_waddr_s, ex_result_s};

endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage with hand-computed expected values.
module tb_ex_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [139:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id;
    logic         ex_is_load;
    logic         stallreq_for_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int errs;
    int checks;
    int n;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .ex_to_id        (ex_to_id),
        .ex_is_load      (ex_is_load),
        .stallreq_for_ex (stallreq_for_ex),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [75:0] got, input logic [75:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [139:0] mk(input logic [31:0] pc, input logic [3:0] op,
                                        input logic [31:0] s1, input logic [31:0] s2,
                                        input logic [1:0] mop, input logic we,
                                        input logic [4:0] wa, input logic [31:0] sd);
        return {pc, op, s1, s2, mop, we, wa, sd};
    endfunction

    function automatic logic [75:0] expm(input logic [31:0] pc, input logic en,
                                         input logic [3:0] wen, input logic we,
                                         input logic [4:0] wa, input logic [31:0] res);
        return {pc, en, wen, 1'b0, we, wa, res};
    endfunction

    task automatic issue(input logic [139:0] bus);
        id_to_ex_bus = bus;
        stall = 6'b000000;
        tick();
    endtask

    task automatic alu_case(input string tag, input logic [3:0] op, input logic [31:0] s1,
                            input logic [31:0] s2, input logic [31:0] exp);
        issue(mk(32'h0000_1000, op, s1, s2, 2'b00, 1'b1, 5'd7, 32'd0));
        chk({tag, "_bus"}, ex_to_mem_bus, expm(32'h0000_1000, 1'b0, 4'b0000, 1'b1, 5'd7, exp));
        chk({tag, "_fwd"}, {38'd0, ex_to_id}, {38'd0, 1'b1, 5'd7, exp});
    endtask

    // Hold EX while the divider asks for it; n counts stall-request cycles (bounded).
    task automatic run_div();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (stallreq_for_ex) begin
                stall = 6'b001111;
                n++;
                tick();
            end
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        issue(mk(32'h0000_3000, 4'd14, 32'd0, 32'd0, 2'b00, 1'b1, 5'd2, 32'd0));
        chk({tag, "_lo"}, {44'd0, ex_to_mem_bus[31:0]}, {44'd0, exp_lo});
        issue(mk(32'h0000_3004, 4'd13, 32'd0, 32'd0, 2'b00, 1'b1, 5'd3, 32'd0));
        chk({tag, "_hi"}, {44'd0, ex_to_mem_bus[31:0]}, {44'd0, exp_hi});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        errs = 0;
        checks = 0;
        rst = 1'b1;
        stall = 6'b000000;
        id_to_ex_bus = mk(32'h0000_0100, 4'd0, 32'd1, 32'd2, 2'b01, 1'b1, 5'd1, 32'd5);
        tick();
        tick();
        chk("rst_bus", ex_to_mem_bus, 76'd0);
        chk("rst_fwd", {38'd0, ex_to_id}, 76'd0);
        chk("rst_en", {75'd0, data_sram_en}, 76'd0);
        chk("rst_stallreq", {75'd0, stallreq_for_ex}, 76'd0);
        rst = 1'b0;

        alu_case("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        alu_case("sub", 4'd1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        alu_case("sra", 4'd7, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000);
        alu_case("srl", 4'd6, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000);
        alu_case("slt", 4'd8, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
        alu_case("sltu", 4'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        alu_case("lui", 4'd10, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000);

        issue(mk(32'h0000_2000, 4'd0, 32'h0000_0200, 32'h0000_0004, 2'b01, 1'b1, 5'd9, 32'd0));
        chk("lw_bus", ex_to_mem_bus, expm(32'h0000_2000, 1'b1, 4'b0000, 1'b1, 5'd9, 32'h0000_0204));
        chk("lw_isload", {75'd0, ex_is_load}, 76'd1);
        chk("lw_addr", {44'd0, data_sram_addr}, {44'd0, 32'h0000_0204});

        issue(mk(32'h0000_2004, 4'd0, 32'h0000_0100, 32'h0000_0003, 2'b11, 1'b0, 5'd0, 32'h0000_00AB));
        chk("sb_wen", {72'd0, data_sram_wen}, {72'd0, 4'b1000});
        chk("sb_wdata", {44'd0, data_sram_wdata}, {44'd0, 32'hABAB_ABAB});
        chk("sb_addr", {44'd0, data_sram_addr}, {44'd0, 32'h0000_0103});
        chk("sb_bus", ex_to_mem_bus, expm(32'h0000_2004, 1'b1, 4'b1000, 1'b0, 5'd0, 32'h0000_0103));
        chk("sb_isload", {75'd0, ex_is_load}, 76'd0);

        issue(mk(32'h0000_2008, 4'd0, 32'h0000_0040, 32'h0000_0000, 2'b10, 1'b0, 5'd0, 32'hDEAD_BEEF));
        chk("sw_wen", {72'd0, data_sram_wen}, {72'd0, 4'b1111});
        chk("sw_wdata", {44'd0, data_sram_wdata}, {44'd0, 32'hDEAD_BEEF});

        // Signed -7/2: 33 stall cycles, then mflo/mfhi see the fresh result.
        issue(mk(32'h0000_4000, 4'd11, 32'hFFFF_FFF9, 32'h0000_0002, 2'b00, 1'b0, 5'd0, 32'd0));
        run_div();
        chk("div_stall_cycles", 76'(n), 76'd33);
        read_hilo("div_neg", 32'hFFFF_FFFD, 32'hFFFF_FFFF);

        issue(mk(32'h0000_4100, 4'd12, 32'h0000_0005, 32'h0000_0000, 2'b00, 1'b0, 5'd0, 32'd0));
        run_div();
        chk("divu0_stall_cycles", 76'(n), 76'd33);
        read_hilo("divu0", 32'hFFFF_FFFF, 32'h0000_0005);

        // 100 / -7 held by a downstream stall: must not restart, then bubble.
        issue(mk(32'h0000_4200, 4'd11, 32'd100, 32'hFFFF_FFF9, 2'b00, 1'b0, 5'd0, 32'd0));
        run_div();
        chk("held_stall_cycles", 76'(n), 76'd33);
        for (int i = 0; i < 3; i++) begin
            stall = 6'b001111;
            tick();
            chk("held_no_restart", {75'd0, stallreq_for_ex}, 76'd0);
        end
        stall = 6'b000100;
        tick();
        chk("bubble_bus", ex_to_mem_bus, 76'd0);
        read_hilo("held", 32'hFFFF_FFF2, 32'h0000_0002);

        // Reset at divide cycle 10 aborts and clears HI/LO.
        issue(mk(32'h0000_4300, 4'd12, 32'd1000, 32'd3, 2'b00, 1'b0, 5'd0, 32'd0));
        for (int i = 0; i < 10; i++) begin
            stall = 6'b001111;
            tick();
        end
        chk("mid_div_busy", {75'd0, stallreq_for_ex}, 76'd1);
        rst = 1'b1;
        stall = 6'b000000;
        tick();
        rst = 1'b0;
        chk("abort_stallreq", {75'd0, stallreq_for_ex}, 76'd0);
        chk("abort_bus", ex_to_mem_bus, 76'd0);
        chk("abort_fwd", {38'd0, ex_to_id}, 76'd0);
        chk("abort_en", {75'd0, data_sram_en}, 76'd0);
        read_hilo("abort", 32'h0000_0000, 32'h0000_0000);
        chk("abort_no_resume", {75'd0, stallreq_for_ex}, 76'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
